pingpong_collector: RTL and testbench
=====================================

Name: pingpong_collector

Overview:
- Recombines the two AXI-Stream branches produced by the ping-pong splitter into one output stream, after per-branch processing.
- Strict round-robin at group granularity: PP_GROUP whole packets from IN1, then PP_GROUP whole packets from IN2, and so on.
- This restores the original packet order.
- Packet boundaries come from TLAST. The non-selected branch is back-pressured.
- Output is a registered, full-throughput stage.

Parameters:
DW  512  data width in bits; TKEEP width is DW/8

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
PP_GROUP  in  32  packets per group per branch; 0 is treated as 1
AXIS_IN1_TDATA  in  DW  branch 1 data
AXIS_IN1_TKEEP  in  DW/8  branch 1 byte enables
AXIS_IN1_TLAST  in  1  branch 1 end of packet
AXIS_IN1_TVALID  in  1  branch 1 valid
AXIS_IN1_TREADY  out  1  branch 1 ready
AXIS_IN2_TDATA  in  DW  branch 2 data
AXIS_IN2_TKEEP  in  DW/8  branch 2 byte enables
AXIS_IN2_TLAST  in  1  branch 2 end of packet
AXIS_IN2_TVALID  in  1  branch 2 valid
AXIS_IN2_TREADY  out  1  branch 2 ready
AXIS_OUT_TDATA  out  DW  merged data
AXIS_OUT_TKEEP  out  DW/8  merged byte enables
AXIS_OUT_TLAST  out  1  merged end of packet
AXIS_OUT_TVALID  out  1  merged valid
AXIS_OUT_TREADY  in  1  downstream ready
CUR_SEL  out  1  0 = IN1 selected, 1 = IN2 selected
GROUP_COUNT  out  32  completed groups since reset; wraps at 2^32

Behaviour:
- Reset (asynchronous, immediate, active-high):
  - sel=0 (state SEL1), pkt_cnt=0, grp_lat=max(PP_GROUP,1), GROUP_COUNT=0.
  - AXIS_OUT_TVALID=0; OUT TDATA/TKEEP/TLAST=0.
  - Both TREADYs deassert asynchronously.
- Reset mid-packet or mid-group:
  - The in-flight output beat is dropped.
  - The collector restarts at IN1 with a fresh group. No recovery of partial packets.
- Output stage is a single register:
  - load_en = !OUT_TVALID | OUT_TREADY.
  - IN1_TREADY = !reset & (sel==0) & load_en; IN2_TREADY = !reset & (sel==1) & load_en. Combinational from OUT_TREADY.
  - Non-selected TREADY is always 0.
- Beat accept:
  - Accept when selected TVALID & TREADY. Next edge: OUT regs <= selected TDATA/TKEEP/TLAST, OUT_TVALID <= 1.
  - If load_en & no accept, OUT_TVALID <= 0.
  - Latency 1 cycle. Throughput 1 beat/cycle while the selected branch streams and downstream is ready.
- Output rules:
  - OUT data/keep/last are held stable while OUT_TVALID & !OUT_TREADY.
  - TKEEP passes through unmodified.
- States: SEL1 (sel=0), SEL2 (sel=1). Transitions happen only on an accepted beat with TLAST=1 (tlast_acc):
  - If pkt_cnt == grp_lat-1: toggle sel, pkt_cnt <= 0, GROUP_COUNT <= GROUP_COUNT+1, grp_lat <= max(PP_GROUP,1) sampled that cycle.
  - Else: pkt_cnt <= pkt_cnt+1.
- Switch timing:
  - The switch takes effect the cycle after the last beat is accepted. No dead cycle.
  - The new branch's TREADY may be 1 on the very next cycle.
- PP_GROUP changes:
  - Take effect only at a group boundary. Mid-group changes are ignored until then.
- Width rules:
  - pkt_cnt is 32-bit; compare against grp_lat-1 in 32 bits. PP_GROUP=0xFFFFFFFF is legal.
  - GROUP_COUNT wraps modulo 2^32.
- Idle/stall behaviour:
  - A TVALID held on the non-selected branch is ignored indefinitely; TREADY stays 0.
  - The selected branch stalling does not change the schedule.
- Out of scope:
  - A single-beat packet (TLAST on first beat) counts as one packet.
  - TLAST is not checked against packet length; length checking is the splitter's responsibility.
- CUR_SEL = sel (registered).

Decomposition:
- No shared package needed beyond DW.
- A local constant for the state encoding (SEL1=0, SEL2=1).
- One natural sub-module, axis_out_reg: a single-entry AXI-Stream register slice with load_en/hold logic, reusable by other blocks.
- The scheduler counter/FSM stays in the top.

Test Plan:
- PP_GROUP=2, 4-beat packets, both branches always valid, OUT_TREADY=1 -> output is IN1 pkts 0,1 then IN2 pkts 0,1, repeating; no bubbles; GROUP_COUNT increments every 8 beats; CUR_SEL toggles the cycle after each 8th beat.
- PP_GROUP=0, 1-beat packets -> strict beat alternation IN1,IN2,IN1; GROUP_COUNT=1,2,3.
- OUT_TREADY pattern 1,0,0,1 repeating, PP_GROUP=1 -> no beat lost or duplicated; OUT data stable while stalled; scoreboard matches ordered stream.
- IN2 TVALID held high from reset while IN1 is idle for 20 cycles -> IN2_TREADY=0 throughout, OUT_TVALID=0, CUR_SEL=0.
- PP_GROUP changed 3->1 mid-group -> current group still completes 3 IN1 packets; subsequent groups are 1 packet each.
- Reset asserted mid-packet on IN2 with OUT_TVALID=1 -> OUT_TVALID=0 and both TREADY=0 immediately (before the next edge); after release CUR_SEL=0, GROUP_COUNT=0, and the first output beat comes from IN1.

Source files
------------

// File: rtl/pingpong_collector_pkg.sv
// Shared definitions for the ping-pong collector: data width, branch select encoding,
// and the group-size normalisation (zero behaves as one).
package pingpong_collector_pkg;

   localparam int PP_DW = 512;

   typedef enum logic {
      SEL1 = 1'b0,
      SEL2 = 1'b1
   } sel_t;

   function automatic logic [31:0] grp_norm(input logic [31:0] g);
      return (g == 32'd0) ? 32'd1 : g;
   endfunction

endpackage

// File: rtl/pingpong_collector_axis_out_reg.sv
// Single-entry AXI-Stream register slice: 1-cycle latency, full throughput,
// holds its beat while downstream stalls and exposes load_en for upstream ready.
module axis_out_reg #(
   parameter int DW = 512
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_load,
   input  logic [DW-1:0]   i_tdata,
   input  logic [DW/8-1:0] i_tkeep,
   input  logic            i_tlast,
   output logic            o_load_en,
   output logic [DW-1:0]   o_tdata,
   output logic [DW/8-1:0] o_tkeep,
   output logic            o_tlast,
   output logic            o_tvalid,
   input  logic            i_tready
);

   logic [DW-1:0]   r_tdata;
   logic [DW/8-1:0] r_tkeep;
   logic            r_tlast;
   logic            r_tvalid;

   assign o_load_en = !r_tvalid || i_tready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b0;
      end else if (o_load_en) begin
         r_tvalid <= i_load;
         if (i_load) begin
            r_tdata <= i_tdata;
            r_tkeep <= i_tkeep;
            r_tlast <= i_tlast;
         end
      end
   end

   assign o_tdata  = r_tdata;
   assign o_tkeep  = r_tkeep;
   assign o_tlast  = r_tlast;
   assign o_tvalid = r_tvalid;

endmodule

// File: rtl/pingpong_collector.sv
// Merges two AXI-Stream branches, PP_GROUP packets from each in turn; 1-cycle latency,
// the unselected branch and a stalled output both see TREADY low.
module pingpong_collector
   import pingpong_collector_pkg::*;
#(
   parameter int DW = PP_DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     PP_GROUP,
   input  logic [DW-1:0]   AXIS_IN1_TDATA,
   input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
   input  logic            AXIS_IN1_TLAST,
   input  logic            AXIS_IN1_TVALID,
   output logic            AXIS_IN1_TREADY,
   input  logic [DW-1:0]   AXIS_IN2_TDATA,
   input  logic [DW/8-1:0] AXIS_IN2_TKEEP,
   input  logic            AXIS_IN2_TLAST,
   input  logic            AXIS_IN2_TVALID,
   output logic            AXIS_IN2_TREADY,
   output logic [DW-1:0]   AXIS_OUT_TDATA,
   output logic [DW/8-1:0] AXIS_OUT_TKEEP,
   output logic            AXIS_OUT_TLAST,
   output logic            AXIS_OUT_TVALID,
   input  logic            AXIS_OUT_TREADY,
   output logic            CUR_SEL,
   output logic [31:0]     GROUP_COUNT
);

   sel_t        r_sel;
   logic [31:0] r_pkt_cnt;
   logic [31:0] r_grp_lat;
   logic [31:0] r_group_count;
   logic        r_fresh;

   logic            w_load_en;
   logic            w_accept;
   logic [DW-1:0]   w_tdata;
   logic [DW/8-1:0] w_tkeep;
   logic            w_tlast;
   logic [31:0]     w_grp_eff;
   logic            w_grp_end;

   assign AXIS_IN1_TREADY = !reset && (r_sel == SEL1) && w_load_en;
   assign AXIS_IN2_TREADY = !reset && (r_sel == SEL2) && w_load_en;

   assign w_accept = (r_sel == SEL1) ? (AXIS_IN1_TVALID && AXIS_IN1_TREADY)
                                     : (AXIS_IN2_TVALID && AXIS_IN2_TREADY);
   assign w_tdata  = (r_sel == SEL1) ? AXIS_IN1_TDATA : AXIS_IN2_TDATA;
   assign w_tkeep  = (r_sel == SEL1) ? AXIS_IN1_TKEEP : AXIS_IN2_TKEEP;
   assign w_tlast  = (r_sel == SEL1) ? AXIS_IN1_TLAST : AXIS_IN2_TLAST;

   // Until the first clock after reset the group size tracks PP_GROUP live, which
   // gives the reset-time sample without an asynchronous load of a data input.
   assign w_grp_eff = r_fresh ? grp_norm(PP_GROUP) : r_grp_lat;
   assign w_grp_end = w_accept && w_tlast && (r_pkt_cnt == w_grp_eff - 32'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel         <= SEL1;
         r_pkt_cnt     <= 32'd0;
         r_grp_lat     <= 32'd1;
         r_fresh       <= 1'b1;
         r_group_count <= 32'd0;
      end else begin
         r_fresh <= 1'b0;
         if (r_fresh || w_grp_end)
            r_grp_lat <= grp_norm(PP_GROUP);
         if (w_accept && w_tlast) begin
            if (w_grp_end) begin
               r_sel         <= (r_sel == SEL1) ? SEL2 : SEL1;
               r_pkt_cnt     <= 32'd0;
               r_group_count <= r_group_count + 32'd1;
            end else begin
               r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
         end
      end
   end

   axis_out_reg #(.DW(DW)) u_out_reg (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_load    (w_accept),
      .i_tdata   (w_tdata),
      .i_tkeep   (w_tkeep),
      .i_tlast   (w_tlast),
      .o_load_en (w_load_en),
      .o_tdata   (AXIS_OUT_TDATA),
      .o_tkeep   (AXIS_OUT_TKEEP),
      .o_tlast   (AXIS_OUT_TLAST),
      .o_tvalid  (AXIS_OUT_TVALID),
      .i_tready  (AXIS_OUT_TREADY)
   );

   assign CUR_SEL     = r_sel;
   assign GROUP_COUNT = r_group_count;

endmodule

// File: tb/tb_pingpong_collector.sv
// Directed bench for pingpong_collector: two always-ready sources with tagged beats,
// hand-derived expected output order, group counts and select timing.
module tb_pingpong_collector;
   import pingpong_collector_pkg::*;

   localparam int DW = PP_DW;
   localparam int KW = DW / 8;

   logic            clk;
   logic            reset;
   logic [31:0]     PP_GROUP;
   logic [DW-1:0]   AXIS_IN1_TDATA;
   logic [KW-1:0]   AXIS_IN1_TKEEP;
   logic            AXIS_IN1_TLAST;
   logic            AXIS_IN1_TVALID;
   logic            AXIS_IN1_TREADY;
   logic [DW-1:0]   AXIS_IN2_TDATA;
   logic [KW-1:0]   AXIS_IN2_TKEEP;
   logic            AXIS_IN2_TLAST;
   logic            AXIS_IN2_TVALID;
   logic            AXIS_IN2_TREADY;
   logic [DW-1:0]   AXIS_OUT_TDATA;
   logic [KW-1:0]   AXIS_OUT_TKEEP;
   logic            AXIS_OUT_TLAST;
   logic            AXIS_OUT_TVALID;
   logic            AXIS_OUT_TREADY;
   logic            CUR_SEL;
   logic [31:0]     GROUP_COUNT;

   pingpong_collector #(.DW(DW)) dut (
      .clk             (clk),
      .reset           (reset),
      .PP_GROUP        (PP_GROUP),
      .AXIS_IN1_TDATA  (AXIS_IN1_TDATA),
      .AXIS_IN1_TKEEP  (AXIS_IN1_TKEEP),
      .AXIS_IN1_TLAST  (AXIS_IN1_TLAST),
      .AXIS_IN1_TVALID (AXIS_IN1_TVALID),
      .AXIS_IN1_TREADY (AXIS_IN1_TREADY),
      .AXIS_IN2_TDATA  (AXIS_IN2_TDATA),
      .AXIS_IN2_TKEEP  (AXIS_IN2_TKEEP),
      .AXIS_IN2_TLAST  (AXIS_IN2_TLAST),
      .AXIS_IN2_TVALID (AXIS_IN2_TVALID),
      .AXIS_IN2_TREADY (AXIS_IN2_TREADY),
      .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
      .AXIS_OUT_TKEEP  (AXIS_OUT_TKEEP),
      .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
      .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
      .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
      .CUR_SEL         (CUR_SEL),
      .GROUP_COUNT     (GROUP_COUNT)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   int   pkt1, beat1, pkt2, beat2, plen;
   logic v1, v2, ordy;
   logic r1, r2;
   logic s_ovld;
   logic [DW-1:0] s_odata;

   int b_tab  [8] = '{1, 1, 1, 2, 1, 2, 1, 2};
   int p_tab  [8] = '{0, 1, 2, 0, 3, 1, 4, 2};
   int gc_tab [8] = '{0, 0, 1, 2, 3, 4, 5, 6};

   function automatic logic [DW-1:0] mk_data(input int b, input int p, input int bt);
      logic [DW-1:0] d;
      d = '0;
      d[31:0]      = {b[7:0], p[15:0], bt[7:0]};
      d[DW-1 -: 16] = 16'hC0DE ^ p[15:0];
      return d;
   endfunction

   function automatic logic [KW-1:0] mk_keep(input int b, input int p, input int bt);
      logic [KW-1:0] k;
      k = '1;
      k[15:0] = {b[3:0], p[7:0], bt[3:0]};
      return k;
   endfunction

   task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed %0h expected %0h", tag, idx, got, exp);
      end
   endtask

   task automatic chkd(input string tag, input int idx, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed %0h expected %0h", tag, idx, got, exp);
      end
   endtask

   task automatic drive();
      AXIS_IN1_TVALID = v1;
      AXIS_IN1_TDATA  = mk_data(1, pkt1, beat1);
      AXIS_IN1_TKEEP  = mk_keep(1, pkt1, beat1);
      AXIS_IN1_TLAST  = (beat1 == plen - 1);
      AXIS_IN2_TVALID = v2;
      AXIS_IN2_TDATA  = mk_data(2, pkt2, beat2);
      AXIS_IN2_TKEEP  = mk_keep(2, pkt2, beat2);
      AXIS_IN2_TLAST  = (beat2 == plen - 1);
      AXIS_OUT_TREADY = ordy;
   endtask

   // One clock: drive at negedge, sample pre-edge handshakes, advance sources, settle 1 after edge.
   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      r1      = AXIS_IN1_TREADY;
      r2      = AXIS_IN2_TREADY;
      s_ovld  = AXIS_OUT_TVALID;
      s_odata = AXIS_OUT_TDATA;
      @(posedge clk);
      if (v1 && r1) begin
         if (beat1 == plen - 1) begin beat1 = 0; pkt1++; end
         else beat1++;
      end
      if (v2 && r2) begin
         if (beat2 == plen - 1) begin beat2 = 0; pkt2++; end
         else beat2++;
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      pkt1 = 0; beat1 = 0; pkt2 = 0; beat2 = 0;
      drive();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      int j, g;
      reset = 1'b1;
      PP_GROUP = 32'd2;
      pkt1 = 0; beat1 = 0; pkt2 = 0; beat2 = 0; plen = 4;
      v1 = 1'b1; v2 = 1'b1; ordy = 1'b1;
      drive();
      #1;
      chk("rst_ovld", 0, 32'(AXIS_OUT_TVALID), 0);
      chkd("rst_odata", 0, AXIS_OUT_TDATA, '0);
      chkd("rst_okeep", 0, DW'(AXIS_OUT_TKEEP), '0);
      chk("rst_olast", 0, 32'(AXIS_OUT_TLAST), 0);
      chk("rst_sel", 0, 32'(CUR_SEL), 0);
      chk("rst_gc", 0, GROUP_COUNT, 0);
      chk("rst_rdy1", 0, 32'(AXIS_IN1_TREADY), 0);
      chk("rst_rdy2", 0, 32'(AXIS_IN2_TREADY), 0);

      // Groups of two 4-beat packets, everything streaming.
      PP_GROUP = 32'd2; plen = 4; v1 = 1'b1; v2 = 1'b1; ordy = 1'b1;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         cycle();
         g = c / 8;
         chkd("g2_data", c, AXIS_OUT_TDATA, mk_data(g % 2 + 1, (g / 2) * 2 + (c % 8) / 4, c % 4));
         chkd("g2_keep", c, DW'(AXIS_OUT_TKEEP), DW'(mk_keep(g % 2 + 1, (g / 2) * 2 + (c % 8) / 4, c % 4)));
         chk("g2_last", c, 32'(AXIS_OUT_TLAST), 32'(c % 4 == 3));
         chk("g2_vld", c, 32'(AXIS_OUT_TVALID), 1);
         chk("g2_gc", c, GROUP_COUNT, (c + 1) / 8);
         chk("g2_sel", c, 32'(CUR_SEL), ((c + 1) / 8) % 2);
      end

      // PP_GROUP=0 acts as 1: single-beat packets alternate strictly.
      PP_GROUP = 32'd0; plen = 1;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cycle();
         chkd("g0_data", c, AXIS_OUT_TDATA, mk_data(c % 2 + 1, c / 2, 0));
         chk("g0_gc", c, GROUP_COUNT, c + 1);
         chk("g0_sel", c, 32'(CUR_SEL), (c + 1) % 2);
      end

      // Downstream ready pattern 1,0,0,1: ordered, lossless, held while stalled.
      PP_GROUP = 32'd1; plen = 2;
      do_reset();
      j = 0;
      for (int c = 0; c < 40; c++) begin
         ordy = (c % 4 == 0) || (c % 4 == 3);
         cycle();
         if (s_ovld) begin
            g = j / 2;
            chkd("bp_data", j, s_odata, mk_data(g % 2 + 1, g / 2, j % 2));
            if (ordy) j++;
         end
      end
      chk("bp_count", 0, j, 19);
      ordy = 1'b1;

      // IN2 pushing while IN1 is idle: nothing moves.
      PP_GROUP = 32'd1; plen = 1; v1 = 1'b0; v2 = 1'b1;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         cycle();
         chk("idle_rdy2", c, 32'(r2), 0);
         chk("idle_ovld", c, 32'(AXIS_OUT_TVALID), 0);
         chk("idle_sel", c, 32'(CUR_SEL), 0);
      end

      // Group size 3 -> 1 mid-group: takes effect only at the boundary.
      PP_GROUP = 32'd3; plen = 1; v1 = 1'b1; v2 = 1'b1;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         cycle();
         if (c == 0) PP_GROUP = 32'd1;
         chkd("chg_data", c, AXIS_OUT_TDATA, mk_data(b_tab[c], p_tab[c], 0));
         chk("chg_gc", c, GROUP_COUNT, gc_tab[c]);
      end

      // Reset mid-packet on IN2 with a beat pending at the output.
      PP_GROUP = 32'd1; plen = 4;
      do_reset();
      for (int c = 0; c < 6; c++) cycle();
      chk("mid_ovld", 0, 32'(AXIS_OUT_TVALID), 1);
      chk("mid_sel", 0, 32'(CUR_SEL), 1);
      chkd("mid_data", 0, AXIS_OUT_TDATA, mk_data(2, 0, 1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_ovld", 0, 32'(AXIS_OUT_TVALID), 0);
      chk("arst_rdy1", 0, 32'(AXIS_IN1_TREADY), 0);
      chk("arst_rdy2", 0, 32'(AXIS_IN2_TREADY), 0);
      pkt1 = 0; beat1 = 0; pkt2 = 0; beat2 = 0;
      drive();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      chk("post_sel", 0, 32'(CUR_SEL), 0);
      chk("post_gc", 0, GROUP_COUNT, 0);
      cycle();
      chk("post_ovld", 0, 32'(AXIS_OUT_TVALID), 1);
      chkd("post_data", 0, AXIS_OUT_TDATA, mk_data(1, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
